regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive cycles the long unit may lose arbitration before it is given priority (range 1..15).
REQ-002 SHALL have clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have issue_valid  input  1  decode presents an instruction for issue.
REQ-004 SHALL have issue_rs1_s, issue_rs2_s, issue_rd_s  input  5 each  source and destination register indices.
REQ-005 SHALL have issue_long  input  1  instruction executes in the multi-cycle unit.
REQ-006 SHALL have issue_stall  output  1  decode must hold the instruction.
REQ-007 SHALL have p_valid  input  1, p_rd_s  input  5, p_rd_v  input  32, p_ready  output  1  pipeline writeback requester.
REQ-008 SHALL have m_valid  input  1, m_rd_s  input  5, m_rd_v  input  32, m_ready  output  1  multi-cycle unit writeback requester.
REQ-009 SHALL have regf_we  output  1, rd_s  output  5, rd_v  output  32  register file write port.
REQ-010 SHALL have conflict_cnt  output  32  count of cycles in which both requesters were valid.

Function
REQ-011 SHALL transfer a requester's write when its valid and ready are both high on a rising clk edge.
REQ-012 SHALL drive m_ready = !p_valid || (starve_cnt == STARVE_LIMIT), combinationally.
REQ-013 SHALL drive p_ready = !(m_valid && starve_cnt == STARVE_LIMIT), combinationally; exactly one requester SHALL transfer when both are valid.
REQ-014 SHALL increment starve_cnt, saturating at STARVE_LIMIT, in each cycle with m_valid && !m_ready, and clear it to 0 on every m transfer.
REQ-015 SHALL register the granted write: the cycle after a transfer, regf_we=1 and rd_s/rd_v equal the transferred values; otherwise regf_we=0 and rd_s/rd_v hold their previous values.
REQ-016 SHALL force regf_we=0 for a transfer with rd_s==0 (write dropped, handshake still completes).
REQ-017 SHALL keep a 32-bit busy vector; bit r is set on the edge at which an issue with issue_valid && !issue_stall && issue_long && issue_rd_s==r, r!=0, is accepted.
REQ-018 SHALL clear busy[m_rd_s] on the edge at which m transfers.
REQ-019 SHALL assert issue_stall = issue_valid && any of busy[issue_rs1_s], busy[issue_rs2_s], busy[issue_rd_s] set, with index 0 never busy.
REQ-020 SHALL compute issue_stall from the registered busy vector only; a clear occurring in the same cycle SHALL NOT release the stall until the next cycle.
REQ-021 SHALL, if set and clear target the same index in the same edge, leave the bit set.
REQ-022 SHALL drive issue_stall=0 when issue_valid=0.

Reset
REQ-023 SHALL on rst clear busy, starve_cnt, regf_we, rd_s, rd_v and conflict_cnt to 0.
REQ-024 SHALL treat valid inputs as don't-care during rst; no transfer is recorded on a reset edge, and an in-flight registered write is discarded.

Configuration
REQ-025 SHALL, with REGFILE_WB_ARBITER_STATS_EN defined, increment conflict_cnt (wrapping at 2^32) in each non-reset cycle with p_valid && m_valid.
REQ-026 SHALL, without REGFILE_WB_ARBITER_STATS_EN, tie conflict_cnt to 0 and contain no counter logic.

Structure
REQ-027 SHALL place the grant enum (GNT_NONE, GNT_PIPE, GNT_LONG) and a REG_IDX_W=5 constant in the shared rv32i_types package.
REQ-028 SHALL implement the busy vector and stall logic as sub-module regfile_scoreboard.

Verification
REQ-029 SHALL cover: p_valid only, p_rd_s=5, p_rd_v=0xDEADBEEF -> next cycle regf_we=1, rd_s=5, rd_v=0xDEADBEEF.
REQ-030 SHALL cover: p_valid and m_valid held high with STARVE_LIMIT=4 -> p wins 4 cycles, m_ready=1 on cycle 5, starve_cnt returns to 0.
REQ-031 SHALL cover: long issue rd=7 accepted, then issue rs1=7 -> issue_stall=1 until the cycle after m transfers m_rd_s=7.
REQ-032 SHALL cover: long issue rd=0 -> busy remains 0; p transfer with p_rd_s=0 -> regf_we stays 0.
REQ-033 SHALL cover: rst asserted while busy[3]=1 and starve_cnt=2 -> all state 0 next cycle, issue_stall=0.
REQ-034 SHALL cover: with REGFILE_WB_ARBITER_STATS_EN, 10 cycles of both valid -> conflict_cnt=10; without it -> 0.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared rv32i register-file types and constants
// Purpose: register index width, data width and the writeback grant encoding
//          used by the writeback arbiter and its scoreboard.
// Ports:   none (package).
package rv32i_types;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_LONG = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-register scoreboard for long-latency writes
// Purpose: tracks destination registers owned by the multi-cycle unit and
//          stalls decode on any source/destination hazard.
// Ports:   clk, rst (sync, active-high)
//          issue_valid, issue_rs1_s, issue_rs2_s, issue_rd_s, issue_long : decode
//          issue_stall  : decode must hold the instruction
//          clr_en, clr_idx : multi-cycle writeback completing for clr_idx
module regfile_scoreboard
    import rv32i_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rs1_s,
    input  logic [REG_IDX_W-1:0] issue_rs2_s,
    input  logic [REG_IDX_W-1:0] issue_rd_s,
    input  logic                 issue_long,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    output logic                 issue_stall
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Stall looks only at the registered vector, so a completion on this edge
    // releases the hazard one cycle later. x0 is never marked busy.
    assign issue_stall = issue_valid &&
                         (busy[issue_rs1_s] || busy[issue_rs2_s] || busy[issue_rd_s]);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && !issue_stall && issue_long && (issue_rd_s != '0))
            set_mask[issue_rd_s] = 1'b1;
        if (clr_en)
            clr_mask[clr_idx] = 1'b1;
    end

    // Clear before set: a new owner issued on the completing edge keeps the bit.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= (busy & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter with starvation guard
// Purpose: arbitrates the single register-file write port between the pipeline
//          and the multi-cycle unit; pipeline wins unless the multi-cycle unit
//          has lost STARVE_LIMIT consecutive cycles. Hosts the busy scoreboard.
// Config:  REGFILE_WB_ARBITER_STATS_EN adds the conflict_cnt counter.
// Ports:   clk, rst (sync, active-high)
//          issue_valid, issue_rs1_s, issue_rs2_s, issue_rd_s, issue_long, issue_stall
//          p_valid, p_rd_s, p_rd_v, p_ready : pipeline writeback requester
//          m_valid, m_rd_s, m_rd_v, m_ready : multi-cycle writeback requester
//          regf_we, rd_s, rd_v : registered register-file write port
//          conflict_cnt : cycles with both requesters valid
module regfile_wb_arbiter
    import rv32i_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rs1_s,
    input  logic [REG_IDX_W-1:0] issue_rs2_s,
    input  logic [REG_IDX_W-1:0] issue_rd_s,
    input  logic                 issue_long,
    output logic                 issue_stall,
    input  logic                 p_valid,
    input  logic [REG_IDX_W-1:0] p_rd_s,
    input  logic [XLEN-1:0]      p_rd_v,
    output logic                 p_ready,
    input  logic                 m_valid,
    input  logic [REG_IDX_W-1:0] m_rd_s,
    input  logic [XLEN-1:0]      m_rd_v,
    output logic                 m_ready,
    output logic                 regf_we,
    output logic [REG_IDX_W-1:0] rd_s,
    output logic [XLEN-1:0]      rd_v,
    output logic [31:0]          conflict_cnt
);

    logic [3:0] starve_cnt;
    logic       at_limit;
    logic       m_fire;
    gnt_e       gnt;

    assign at_limit = (starve_cnt == 4'(STARVE_LIMIT));
    assign m_ready  = !p_valid || at_limit;
    assign p_ready  = !(m_valid && at_limit);
    assign m_fire   = m_valid && m_ready;

    always_comb begin
        gnt = GNT_NONE;
        if (m_fire)
            gnt = GNT_LONG;
        else if (p_valid && p_ready)
            gnt = GNT_PIPE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (m_fire) begin
            starve_cnt <= '0;
        end else if (m_valid && !at_limit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Writes to x0 complete the handshake but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            regf_we <= 1'b0;
            rd_s    <= '0;
            rd_v    <= '0;
        end else begin
            case (gnt)
                GNT_LONG: begin
                    regf_we <= (m_rd_s != '0);
                    rd_s    <= m_rd_s;
                    rd_v    <= m_rd_v;
                end
                GNT_PIPE: begin
                    regf_we <= (p_rd_s != '0);
                    rd_s    <= p_rd_s;
                    rd_v    <= p_rd_v;
                end
                default: regf_we <= 1'b0;
            endcase
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1_s (issue_rs1_s),
        .issue_rs2_s (issue_rs2_s),
        .issue_rd_s  (issue_rd_s),
        .issue_long  (issue_long),
        .clr_en      (m_fire),
        .clr_idx     (m_rd_s),
        .issue_stall (issue_stall)
    );

`ifdef REGFILE_WB_ARBITER_STATS_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk) begin
        if (rst)
            conflict_q <= '0;
        else if (p_valid && m_valid)
            conflict_q <= conflict_q + 32'd1;
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1_s = '0;
    logic [4:0]  issue_rs2_s = '0;
    logic [4:0]  issue_rd_s  = '0;
    logic        issue_long  = 1'b0;
    logic        issue_stall;
    logic        p_valid = 1'b0;
    logic [4:0]  p_rd_s  = '0;
    logic [31:0] p_rd_v  = '0;
    logic        p_ready;
    logic        m_valid = 1'b0;
    logic [4:0]  m_rd_s  = '0;
    logic [31:0] m_rd_v  = '0;
    logic        m_ready;
    logic        regf_we;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [31:0] conflict_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rs1_s  (issue_rs1_s),
        .issue_rs2_s  (issue_rs2_s),
        .issue_rd_s   (issue_rd_s),
        .issue_long   (issue_long),
        .issue_stall  (issue_stall),
        .p_valid      (p_valid),
        .p_rd_s       (p_rd_s),
        .p_rd_v       (p_rd_v),
        .p_ready      (p_ready),
        .m_valid      (m_valid),
        .m_rd_s       (m_rd_s),
        .m_rd_v       (m_rd_v),
        .m_ready      (m_ready),
        .regf_we      (regf_we),
        .rd_s         (rd_s),
        .rd_v         (rd_v),
        .conflict_cnt (conflict_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rs1_s = '0;
        issue_rs2_s = '0;
        issue_rd_s  = '0;
        p_valid     = 1'b0;
        m_valid     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        issue_valid = 1'b1;
        issue_rs1_s = 5'd3;
        issue_rs2_s = 5'd4;
        issue_rd_s  = 5'd5;
        #1;
        tests_run++;
        if (regf_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %0b expected 0", regf_we); end
        tests_run++;
        if (rd_s !== 5'd0 || rd_v !== 32'd0) begin tests_failed++; $display("FAIL reset_rd got %0d/%0h expected 0/0", rd_s, rd_v); end
        tests_run++;
        if (conflict_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_conflict got %0d expected 0", conflict_cnt); end
        tests_run++;
        if (issue_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %0b expected 0", issue_stall); end
        idle();
        step();
    endtask

    task automatic test_pipe_write();
        p_valid = 1'b1;
        p_rd_s  = 5'd5;
        p_rd_v  = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (p_ready !== 1'b1) begin tests_failed++; $display("FAIL pipe_ready got %0b expected 1", p_ready); end
        step();
        p_valid = 1'b0;
        tests_run++;
        if (regf_we !== 1'b1 || rd_s !== 5'd5 || rd_v !== 32'hDEADBEEF)
            begin tests_failed++; $display("FAIL pipe_write got we=%0b rd=%0d v=%0h expected 1/5/deadbeef", regf_we, rd_s, rd_v); end
        step();
        tests_run++;
        if (regf_we !== 1'b0 || rd_s !== 5'd5 || rd_v !== 32'hDEADBEEF)
            begin tests_failed++; $display("FAIL pipe_hold got we=%0b rd=%0d v=%0h expected 0/5/deadbeef", regf_we, rd_s, rd_v); end
    endtask

    task automatic test_starvation();
        p_valid = 1'b1;
        m_valid = 1'b1;
        m_rd_s  = 5'd9;
        m_rd_v  = 32'h0BAD_F00D;
        for (int c = 1; c <= LIMIT; c++) begin
            p_rd_s = 5'(c + 10);
            p_rd_v = 32'(c);
            #1;
            tests_run++;
            if (m_ready !== 1'b0 || p_ready !== 1'b1)
                begin tests_failed++; $display("FAIL starve_pwin_%0d got m=%0b p=%0b expected 0/1", c, m_ready, p_ready); end
            step();
        end
        #1;
        tests_run++;
        if (m_ready !== 1'b1 || p_ready !== 1'b0)
            begin tests_failed++; $display("FAIL starve_mwin got m=%0b p=%0b expected 1/0", m_ready, p_ready); end
        step();
        #1;
        tests_run++;
        if (regf_we !== 1'b1 || rd_s !== 5'd9 || rd_v !== 32'h0BAD_F00D)
            begin tests_failed++; $display("FAIL starve_mwrite got we=%0b rd=%0d v=%0h expected 1/9/badf00d", regf_we, rd_s, rd_v); end
        tests_run++;
        if (m_ready !== 1'b0 || p_ready !== 1'b1)
            begin tests_failed++; $display("FAIL starve_rearm got m=%0b p=%0b expected 0/1", m_ready, p_ready); end
        idle();
        step();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd_s  = 5'd7;
        issue_rs1_s = 5'd1;
        issue_rs2_s = 5'd2;
        #1;
        tests_run++;
        if (issue_stall !== 1'b0) begin tests_failed++; $display("FAIL sb_accept got %0b expected 0", issue_stall); end
        step();
        issue_long  = 1'b0;
        issue_rs1_s = 5'd7;
        issue_rs2_s = 5'd0;
        issue_rd_s  = 5'd8;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (issue_stall !== 1'b1) begin tests_failed++; $display("FAIL sb_hold_%0d got %0b expected 1", c, issue_stall); end
            step();
        end
        m_valid = 1'b1;
        m_rd_s  = 5'd7;
        m_rd_v  = 32'h77;
        #1;
        tests_run++;
        if (issue_stall !== 1'b1) begin tests_failed++; $display("FAIL sb_clear_same_cycle got %0b expected 1", issue_stall); end
        step();
        m_valid = 1'b0;
        #1;
        tests_run++;
        if (issue_stall !== 1'b0) begin tests_failed++; $display("FAIL sb_released got %0b expected 0", issue_stall); end
        // Set and clear of the same index on one edge: set must survive.
        issue_long  = 1'b1;
        issue_rd_s  = 5'd10;
        issue_rs1_s = 5'd0;
        m_valid     = 1'b1;
        m_rd_s      = 5'd10;
        step();
        m_valid     = 1'b0;
        issue_long  = 1'b0;
        issue_rs1_s = 5'd10;
        issue_rd_s  = 5'd0;
        #1;
        tests_run++;
        if (issue_stall !== 1'b1) begin tests_failed++; $display("FAIL sb_set_wins got %0b expected 1", issue_stall); end
        issue_valid = 1'b0;
        #1;
        tests_run++;
        if (issue_stall !== 1'b0) begin tests_failed++; $display("FAIL sb_no_valid got %0b expected 0", issue_stall); end
        m_valid = 1'b1;
        m_rd_s  = 5'd10;
        step();
        idle();
        step();
    endtask

    task automatic test_zero_reg();
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd_s  = 5'd0;
        step();
        issue_long  = 1'b0;
        #1;
        tests_run++;
        if (issue_stall !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got %0b expected 0", issue_stall); end
        issue_valid = 1'b0;
        p_valid = 1'b1;
        p_rd_s  = 5'd0;
        p_rd_v  = 32'h1234_5678;
        #1;
        tests_run++;
        if (p_ready !== 1'b1) begin tests_failed++; $display("FAIL zero_ready got %0b expected 1", p_ready); end
        step();
        p_valid = 1'b0;
        tests_run++;
        if (regf_we !== 1'b0) begin tests_failed++; $display("FAIL zero_we got %0b expected 0", regf_we); end
        step();
    endtask

    task automatic test_reset_midflight();
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd_s  = 5'd3;
        step();
        idle();
        p_valid = 1'b1;
        m_valid = 1'b1;
        m_rd_s  = 5'd20;
        step();
        step();
        p_rd_s  = 5'd12;
        p_rd_v  = 32'hCAFE;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        issue_valid = 1'b1;
        issue_rs1_s = 5'd3;
        #1;
        tests_run++;
        if (regf_we !== 1'b0 || rd_s !== 5'd0 || rd_v !== 32'd0)
            begin tests_failed++; $display("FAIL rst_mid_wb got we=%0b rd=%0d v=%0h expected 0/0/0", regf_we, rd_s, rd_v); end
        tests_run++;
        if (issue_stall !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got %0b expected 0", issue_stall); end
        tests_run++;
        if (conflict_cnt !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_conflict got %0d expected 0", conflict_cnt); end
        idle();
        p_valid = 1'b1;
        m_valid = 1'b1;
        for (int c = 0; c <= LIMIT; c++) begin
            #1;
            tests_run++;
            if (m_ready !== (c == LIMIT))
                begin tests_failed++; $display("FAIL rst_mid_starve_%0d got %0b expected %0b", c, m_ready, c == LIMIT); end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_conflict();
        int exp;
        do_reset();
        p_valid = 1'b1;
        m_valid = 1'b1;
        repeat (10) step();
        idle();
        #1;
`ifdef REGFILE_WB_ARBITER_STATS_EN
        exp = 10;
`else
        exp = 0;
`endif
        tests_run++;
        if (conflict_cnt !== 32'(exp)) begin tests_failed++; $display("FAIL conflict_cnt got %0d expected %0d", conflict_cnt, exp); end
        step();
    endtask

    task automatic test_random();
        bit          busy[32];
        int          losses;
        bit          e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_v;
        int unsigned conflicts;
        bit          e_stall, e_m, e_p, accept;
        do_reset();
        foreach (busy[i]) busy[i] = 1'b0;
        losses = 0; e_we = 0; e_rd = '0; e_v = '0; conflicts = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst         = ($urandom_range(0, 49) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_long  = $urandom_range(0, 1);
            issue_rs1_s = 5'($urandom_range(0, 7));
            issue_rs2_s = 5'($urandom_range(0, 7));
            issue_rd_s  = 5'($urandom_range(0, 7));
            p_valid     = ($urandom_range(0, 3) != 0);
            m_valid     = $urandom_range(0, 1);
            p_rd_s      = 5'($urandom_range(0, 7));
            m_rd_s      = 5'($urandom_range(0, 7));
            p_rd_v      = $urandom;
            m_rd_v      = $urandom;
            #1;
            e_stall = issue_valid && (busy[issue_rs1_s] || busy[issue_rs2_s] || busy[issue_rd_s]);
            e_m     = m_valid && (!p_valid || losses == LIMIT);
            e_p     = p_valid && !e_m;
            tests_run++;
            if (issue_stall !== e_stall || m_ready !== (!p_valid || losses == LIMIT) || p_ready !== !(m_valid && losses == LIMIT))
                begin tests_failed++; $display("FAIL rand_comb cyc %0d got s=%0b m=%0b p=%0b expected s=%0b losses=%0d", cyc, issue_stall, m_ready, p_ready, e_stall, losses); end
            tests_run++;
            if (regf_we !== e_we || (e_we && (rd_s !== e_rd || rd_v !== e_v)))
                begin tests_failed++; $display("FAIL rand_wb cyc %0d got %0b/%0d/%0h expected %0b/%0d/%0h", cyc, regf_we, rd_s, rd_v, e_we, e_rd, e_v); end
`ifdef REGFILE_WB_ARBITER_STATS_EN
            tests_run++;
            if (conflict_cnt !== 32'(conflicts)) begin tests_failed++; $display("FAIL rand_conflict cyc %0d got %0d expected %0d", cyc, conflict_cnt, conflicts); end
`endif
            accept = issue_valid && !e_stall && issue_long && issue_rd_s != 0;
            if (rst) begin
                foreach (busy[i]) busy[i] = 1'b0;
                losses = 0; e_we = 0; e_rd = '0; e_v = '0; conflicts = 0;
            end else begin
                if (p_valid && m_valid) conflicts++;
                if (e_m) begin
                    e_we = (m_rd_s != 0); e_rd = m_rd_s; e_v = m_rd_v; losses = 0;
                    busy[m_rd_s] = 1'b0;
                end else begin
                    if (m_valid && losses < LIMIT) losses++;
                    if (e_p) begin e_we = (p_rd_s != 0); e_rd = p_rd_s; e_v = p_rd_v; end
                    else e_we = 1'b0;
                end
                if (accept) busy[issue_rd_s] = 1'b1;
            end
            step();
        end
        rst = 1'b0;
        idle();
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_pipe_write();
        test_starvation();
        test_scoreboard();
        test_zero_reg();
        test_reset_midflight();
        test_conflict();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
